// File: rtl/result_drain.sv
// ---------------------------------------------------------------------------
// result_drain
//
// Captures a full set of PE result words in one cycle and streams them out
// one word per accepted handshake, then signals completion. The PE array is
// told to clear its accumulators as soon as the capture has been taken, so
// it can start the next computation while the previous results drain.
//
// Ports
//    clk         : single clock, all state updates on the rising edge
//    reset_n     : asynchronous active-low reset
//    results_in  : flattened PE results, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//    start       : single-cycle capture request (only honoured when idle)
//    out_ready   : downstream accepts the current word
//    out_data    : current output word
//    out_valid   : out_data holds a valid word
//    out_last    : current word is the final one (qualified by out_valid)
//    out_index   : index of the current word
//    pe_clear    : one-cycle pulse, coincident with the first output word
//    busy        : high whenever the drain is not idle
//    done        : one-cycle pulse after the final word is accepted
//    drop_count  : saturating count of start requests ignored while busy
// ---------------------------------------------------------------------------
module result_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PE     = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_PE*DATA_WIDTH-1:0]   results_in,
   input  logic                           start,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_valid,
   output logic                           out_last,
   output logic [$clog2(NUM_PE)-1:0]      out_index,
   output logic                           pe_clear,
   output logic                           busy,
   output logic                           done,
   output logic [7:0]                     drop_count
);

   localparam int IDX_W = $clog2(NUM_PE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  buffer_q [NUM_PE];
   logic [DATA_WIDTH-1:0]  buffer_d [NUM_PE];
   logic [IDX_W-1:0]       index_q, index_d;
   logic [IDX_W-1:0]       nextIndex;
   logic [DATA_WIDTH-1:0]  outData_q, outData_d;
   logic                   outValid_q, outValid_d;
   logic                   outLast_q, outLast_d;
   logic [IDX_W-1:0]       outIndex_q, outIndex_d;
   logic                   peClear_q, peClear_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [7:0]             dropCount_q, dropCount_d;

   assign nextIndex = index_q + IDX_W'(1);

   // Next-state logic. Every output is computed one cycle ahead so that it
   // can be registered; this keeps out_ready and start off any output path.
   // In particular out_data is loaded with the word the index will point to
   // after this edge, rather than being muxed from the buffer afterwards.
   always_comb begin
      state_d     = state_q;
      buffer_d    = buffer_q;
      index_d     = index_q;
      outData_d   = outData_q;
      outValid_d  = outValid_q;
      outLast_d   = outLast_q;
      outIndex_d  = outIndex_q;
      peClear_d   = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dropCount_d = dropCount_q;

      case (state_q)
         IDLE: begin
            busy_d     = 1'b0;
            outValid_d = 1'b0;
            if (start) begin
               for (int k = 0; k < NUM_PE; k++) begin
                  buffer_d[k] = results_in[k*DATA_WIDTH +: DATA_WIDTH];
               end
               index_d    = '0;
               outData_d  = results_in[DATA_WIDTH-1:0];
               outValid_d = 1'b1;
               outLast_d  = 1'b0;
               outIndex_d = '0;
               peClear_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = STREAM;
            end
         end

         STREAM: begin
            if (start && dropCount_q != 8'hFF) begin
               dropCount_d = dropCount_q + 8'd1;
            end
            if (out_ready) begin
               if (index_q == LAST_IDX) begin
                  index_d    = '0;
                  outData_d  = '0;
                  outValid_d = 1'b0;
                  outLast_d  = 1'b0;
                  outIndex_d = '0;
                  done_d     = 1'b1;
                  state_d    = DONE;
               end else begin
                  index_d    = nextIndex;
                  outData_d  = buffer_q[nextIndex];
                  outIndex_d = nextIndex;
                  outLast_d  = (nextIndex == LAST_IDX);
               end
            end
         end

         DONE: begin
            if (start && dropCount_q != 8'hFF) begin
               dropCount_d = dropCount_q + 8'd1;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // State and output registers. Reset wipes the shadow buffer as well so
   // that no stale results survive an abandoned drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         for (int k = 0; k < NUM_PE; k++) begin
            buffer_q[k] <= '0;
         end
         index_q     <= '0;
         outData_q   <= '0;
         outValid_q  <= 1'b0;
         outLast_q   <= 1'b0;
         outIndex_q  <= '0;
         peClear_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dropCount_q <= '0;
      end else begin
         state_q     <= state_d;
         buffer_q    <= buffer_d;
         index_q     <= index_d;
         outData_q   <= outData_d;
         outValid_q  <= outValid_d;
         outLast_q   <= outLast_d;
         outIndex_q  <= outIndex_d;
         peClear_q   <= peClear_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dropCount_q <= dropCount_d;
      end
   end

   assign out_data   = outData_q;
   assign out_valid  = outValid_q;
   assign out_last   = outLast_q;
   assign out_index  = outIndex_q;
   assign pe_clear   = peClear_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign drop_count = dropCount_q;

endmodule

// File: tb/tb_result_drain.sv
// ---------------------------------------------------------------------------
// tb_result_drain
//
// Directed plus randomized bench for result_drain with NUM_PE=4. A simple
// model keeps the captured words as a local copy, counts handshakes and
// ignored start requests, and every observed output is compared with it.
// ---------------------------------------------------------------------------
module tb_result_drain;

   localparam int DW = 32;
   localparam int NP = 4;

   logic                 clk;
   logic                 reset_n;
   logic [NP*DW-1:0]     results_in;
   logic                 start;
   logic                 out_ready;
   logic [DW-1:0]        out_data;
   logic                 out_valid;
   logic                 out_last;
   logic [1:0]           out_index;
   logic                 pe_clear;
   logic                 busy;
   logic                 done;
   logic [7:0]           drop_count;

   int testCount = 0;
   int failCount = 0;
   int expDrops  = 0;

   result_drain #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .results_in (results_in),
      .start      (start),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_index  (out_index),
      .pe_clear   (pe_clear),
      .busy       (busy),
      .done       (done),
      .drop_count (drop_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] satDrops();
      return (expDrops > 255) ? 64'd255 : 64'(expDrops);
   endfunction

   // Capture 'words', then drain them. readyMode: 0 always ready,
   // 1 pattern 1,0,0,1 repeating, 2 random. out_ready is held low for the
   // first stallCycles cycles; start is asserted for the first dropStarts
   // streaming cycles; scramble changes results_in right after capture.
   task automatic applyStimulus(input logic [NP*DW-1:0] words, input int readyMode,
                                input int stallCycles, input int dropStarts, input bit scramble);
      int k;
      int cyc;
      logic rdy;
      k   = 0;
      cyc = 0;
      results_in = words;
      start      = 1'b1;
      step();
      start = 1'b0;
      if (scramble) results_in = {32'd4, 32'd3, 32'd2, 32'd1};
      while (k < NP && cyc < stallCycles + 100) begin
         checkOutput("out_valid",  64'(out_valid), 64'd1);
         checkOutput("out_data",   64'(out_data),  64'(words[k*DW +: DW]));
         checkOutput("out_index",  64'(out_index), 64'(k));
         checkOutput("out_last",   64'(out_last),  64'(k == NP - 1));
         checkOutput("pe_clear",   64'(pe_clear),  64'(cyc == 0));
         checkOutput("busy",       64'(busy),      64'd1);
         checkOutput("done",       64'(done),      64'd0);
         checkOutput("drop_count", 64'(drop_count), satDrops());
         if (cyc < stallCycles)   rdy = 1'b0;
         else if (readyMode == 0) rdy = 1'b1;
         else if (readyMode == 1) rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else                     rdy = 1'($urandom_range(0, 1));
         out_ready = rdy;
         start     = (cyc < dropStarts);
         step();
         if (start) expDrops++;
         if (rdy) k++;
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b0;
      checkOutput("transfers", 64'(k), 64'(NP));
      checkOutput("done_pulse",     64'(done),      64'd1);
      checkOutput("done_valid",     64'(out_valid), 64'd0);
      checkOutput("done_last",      64'(out_last),  64'd0);
      checkOutput("done_busy",      64'(busy),      64'd1);
      checkOutput("done_pe_clear",  64'(pe_clear),  64'd0);
      step();
      checkOutput("idle_done",  64'(done),       64'd0);
      checkOutput("idle_busy",  64'(busy),       64'd0);
      checkOutput("idle_valid", 64'(out_valid),  64'd0);
      checkOutput("idle_drops", 64'(drop_count), satDrops());
   endtask

   function automatic logic [NP*DW-1:0] randomWords();
      logic [NP*DW-1:0] w;
      for (int i = 0; i < NP; i++) w[i*DW +: DW] = $urandom;
      return w;
   endfunction

   initial begin
      logic [NP*DW-1:0] base;
      logic [NP*DW-1:0] rw;
      base       = {32'd40, 32'd30, 32'd20, 32'd10};
      reset_n    = 1'b1;
      start      = 1'b0;
      out_ready  = 1'b0;
      results_in = '0;

      // Reset asserted before any clock edge: outputs must clear at once.
      #1 reset_n = 1'b0;
      #2;
      checkOutput("rst_valid",    64'(out_valid),  64'd0);
      checkOutput("rst_data",     64'(out_data),   64'd0);
      checkOutput("rst_last",     64'(out_last),   64'd0);
      checkOutput("rst_index",    64'(out_index),  64'd0);
      checkOutput("rst_pe_clear", 64'(pe_clear),   64'd0);
      checkOutput("rst_busy",     64'(busy),       64'd0);
      checkOutput("rst_done",     64'(done),       64'd0);
      checkOutput("rst_drops",    64'(drop_count), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // Basic drain with continuous ready, then an immediate second drain.
      applyStimulus(base, 0, 0, 0, 1'b0);
      applyStimulus(randomWords(), 0, 0, 0, 1'b0);

      // Back-pressure pattern 1,0,0,1.
      applyStimulus(base, 1, 0, 0, 1'b0);

      // Input changes after capture must not leak into the stream.
      applyStimulus(base, 0, 0, 0, 1'b1);

      // Three ignored starts during streaming.
      applyStimulus(base, 0, 0, 3, 1'b0);
      checkOutput("drops_three", 64'(drop_count), 64'd3);

      // 300 ignored starts while stalled: counter saturates.
      applyStimulus(randomWords(), 0, 300, 300, 1'b0);
      checkOutput("drops_sat", 64'(drop_count), 64'd255);

      // Randomized drains with random back-pressure.
      for (int n = 0; n < 10; n++) begin
         applyStimulus(randomWords(), 2, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a drain, after two transfers.
      rw         = randomWords();
      results_in = rw;
      start      = 1'b1;
      step();
      start     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      checkOutput("mid_index", 64'(out_index), 64'd2);
      checkOutput("mid_data",  64'(out_data),  64'(rw[2*DW +: DW]));
      out_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      expDrops = 0;
      checkOutput("mid_rst_valid",    64'(out_valid),  64'd0);
      checkOutput("mid_rst_data",     64'(out_data),   64'd0);
      checkOutput("mid_rst_last",     64'(out_last),   64'd0);
      checkOutput("mid_rst_index",    64'(out_index),  64'd0);
      checkOutput("mid_rst_pe_clear", 64'(pe_clear),   64'd0);
      checkOutput("mid_rst_busy",     64'(busy),       64'd0);
      checkOutput("mid_rst_done",     64'(done),       64'd0);
      checkOutput("mid_rst_drops",    64'(drop_count), 64'd0);
      step();
      checkOutput("mid_rst_no_done", 64'(done), 64'd0);
      reset_n = 1'b1;
      step();
      checkOutput("post_rst_busy", 64'(busy), 64'd0);
      applyStimulus(randomWords(), 0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each PE result word and of out_data.
REQ-002 Parameter NUM_PE, default 4, number of PE result words captured per drain; legal range 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion sampled on clk.
REQ-005 results_in  input  NUM_PE*DATA_WIDTH  flattened PE result bus; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 start  input  1  single-cycle request to capture results_in and stream it out.
REQ-007 out_ready  input  1  downstream acceptance of the current output word.
REQ-008 out_data  output  DATA_WIDTH  current output word.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_last  output  1  current word is word NUM_PE-1; qualified by out_valid.
REQ-011 out_index  output  $clog2(NUM_PE)  index of the current word.
REQ-012 pe_clear  output  1  one-cycle pulse instructing the PE array to zero its accumulators.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse after the last word is accepted.
REQ-015 drop_count  output  8  number of start pulses ignored while busy, saturating.

Function
REQ-016 FSM states are IDLE, STREAM and DONE, encoded in registers.
REQ-017 In IDLE with start=1: all NUM_PE words of results_in are copied into an internal shadow buffer on that edge, the index is set to 0, pe_clear is registered high for exactly the next cycle, and state becomes STREAM.
REQ-018 Capture is single-cycle: results_in is not sampled again until the next accepted start, and later changes to results_in do not affect streamed data.
REQ-019 In STREAM: out_valid=1, out_data=buffer[index], out_index=index, and out_last=1 only when index==NUM_PE-1.
REQ-020 A transfer occurs on any rising edge with out_valid=1 and out_ready=1; the index increments by 1 on each transfer.
REQ-021 While out_valid=1 and out_ready=0: out_data, out_index and out_last are held stable, and out_valid is not withdrawn.
REQ-022 A transfer with index==NUM_PE-1 moves the state to DONE, and the index wraps to 0.
REQ-023 DONE lasts exactly one cycle with done=1 and out_valid=0, then the state returns to IDLE.
REQ-024 In STREAM or DONE, start is ignored, and drop_count increments by 1 unless it is already 255, where it holds.
REQ-025 A start arriving in the cycle after DONE (state IDLE) is accepted normally; the minimum start-to-start spacing is NUM_PE+2 cycles when out_ready is held at 1.
REQ-026 Latency is fixed: the first word is valid on the cycle after start is accepted, and pe_clear is coincident with that first-word cycle.
REQ-027 Data words pass through unmodified: no arithmetic, truncation or sign handling is applied.
REQ-028 out_valid, out_last, pe_clear, done and busy are all driven directly from registers, with no combinational path from out_ready or start.

Reset
REQ-029 When reset_n=0, the following apply immediately: state=IDLE, index=0, shadow buffer=0, out_data=0, out_valid=0, out_last=0, out_index=0, pe_clear=0, busy=0, done=0, drop_count=0.
REQ-030 Reset asserted mid-STREAM abandons the drain without a done pulse; after release, the first start is accepted as a fresh capture.

Verification
REQ-031 NUM_PE=4, results_in words {10,20,30,40}, start pulse, out_ready=1 -> out_data 10,20,30,40 on consecutive cycles starting 1 cycle after start; out_last only with 40; pe_clear high on the 10 cycle; done high the cycle after 40.
REQ-032 Same capture with out_ready toggling 1,0,0,1,... -> each word is held stable while out_ready=0; no word is skipped or duplicated; 4 transfers total.
REQ-033 results_in changed to {1,2,3,4} the cycle after start -> streamed data remains {10,20,30,40}.
REQ-034 Three start pulses during STREAM -> drop_count=3 and streaming is unaffected; 300 ignored starts -> drop_count=255.
REQ-035 reset_n pulled low after the second transfer -> all outputs go to 0 asynchronously with no done pulse; a new start then streams fresh data from index 0.
REQ-036 start asserted the cycle after done -> accepted, and a second full drain of 4 words completes correctly.
